// File: rtl/tawas_rcn_master_pkg.sv
// Shared definitions for the Tawas RACCOON master: FSM encodings, FIFO entry
// layout, default error data and the load-lane extraction helper.
package tawas_rcn_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Queue entry layout: {SWAP, WR, SEL[2:0], MASK[3:0], ADDR[31:0], DATA[31:0]}
  localparam int ENTRY_W  = 73;
  localparam int OFF_DATA = 0;
  localparam int OFF_ADDR = 32;
  localparam int OFF_MASK = 64;
  localparam int OFF_SEL  = 68;
  localparam int OFF_WR   = 71;
  localparam int OFF_SWAP = 72;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hFFFF_FFFF;

  function automatic logic [31:0] lane_extract(input logic [3:0] mask, input logic [31:0] data);
    logic [31:0] res;
    case (mask)
      4'b0011: res = {16'h0000, data[15:0]};
      4'b1100: res = {16'h0000, data[31:16]};
      4'b0001: res = {24'h000000, data[7:0]};
      4'b0010: res = {24'h000000, data[15:8]};
      4'b0100: res = {24'h000000, data[23:16]};
      4'b1000: res = {24'h000000, data[31:24]};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tawas_rcn_fifo.sv
// Small synchronous FIFO with show-ahead head output and registered full flag.
module tawas_rcn_fifo #(
  parameter int WIDTH = 73,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             full_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full_reg;
  assign do_pop  = pop && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop)
      count_next = count_reg + CW'(1);
    else if (!do_push && do_pop)
      count_next = count_reg - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = full_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/tawas_rcn_master.sv
// Queues RACCOON requests from the Tawas load/store stage, issues them one at a
// time on the raccoon bus and writes load/swap results back to the register file.
module tawas_rcn_master
  import tawas_rcn_master_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RACCOON_CS,
  input  logic        RACCOON_SWAP,
  input  logic [2:0]  WRITEBACK_REG,
  input  logic [31:0] DADDR,
  input  logic        DWR,
  input  logic [3:0]  DMASK,
  input  logic [31:0] DOUT,
  output logic        RC_FULL,
  output logic        RC_BUSY,
  output logic        RC_OVERFLOW,
  output logic        RCN_REQ_VLD,
  input  logic        RCN_REQ_RDY,
  output logic [31:0] RCN_REQ_ADDR,
  output logic        RCN_REQ_WR,
  output logic        RCN_REQ_SWAP,
  output logic [3:0]  RCN_REQ_MASK,
  output logic [31:0] RCN_REQ_DATA,
  input  logic        RCN_RSP_VLD,
  input  logic        RCN_RSP_ERR,
  input  logic [31:0] RCN_RSP_DATA,
  output logic        RC_LOAD_VLD,
  output logic [2:0]  RC_LOAD_SEL,
  output logic [31:0] RC_LOAD,
  output logic        RC_ERR
);

  logic [ENTRY_W-1:0]      fifo_din;
  logic [ENTRY_W-1:0]      fifo_head;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic                    fifo_pop;

  state_t      state_reg;
  logic [7:0]  cnt_reg;
  logic        req_vld_reg;
  logic [31:0] req_addr_reg;
  logic        req_wr_reg;
  logic        req_swap_reg;
  logic [3:0]  req_mask_reg;
  logic [31:0] req_data_reg;
  logic [2:0]  req_sel_reg;
  logic        load_vld_reg;
  logic [2:0]  load_sel_reg;
  logic [31:0] load_reg;
  logic        err_reg;
  logic        overflow_reg;

  logic        rsp_done;
  logic        rsp_fail;
  logic        wants_data;
  logic [31:0] load_data;

  assign fifo_din  = {RACCOON_SWAP, DWR, WRITEBACK_REG, DMASK, DADDR, DOUT};
  assign fifo_push = RACCOON_CS && !fifo_full;
  assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty;

  tawas_rcn_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A timeout is handled exactly like an error response.
  assign rsp_done   = (state_reg == ST_WAIT) &&
                      (RCN_RSP_VLD || (cnt_reg == 8'(TIMEOUT - 1)));
  assign rsp_fail   = !RCN_RSP_VLD || RCN_RSP_ERR;
  assign wants_data = !req_wr_reg || req_swap_reg;
  assign load_data  = rsp_fail ? ERR_DATA : lane_extract(req_mask_reg, RCN_RSP_DATA);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 8'd0;
      req_vld_reg  <= 1'b0;
      req_addr_reg <= 32'd0;
      req_wr_reg   <= 1'b0;
      req_swap_reg <= 1'b0;
      req_mask_reg <= 4'd0;
      req_data_reg <= 32'd0;
      req_sel_reg  <= 3'd0;
      load_vld_reg <= 1'b0;
      load_sel_reg <= 3'd0;
      load_reg     <= 32'd0;
      err_reg      <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      load_vld_reg <= 1'b0;
      load_sel_reg <= 3'd0;
      load_reg     <= 32'd0;
      err_reg      <= 1'b0;
      if (RACCOON_CS && fifo_full)
        overflow_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            req_swap_reg <= fifo_head[OFF_SWAP];
            req_wr_reg   <= fifo_head[OFF_WR];
            req_sel_reg  <= fifo_head[OFF_SEL +: 3];
            req_mask_reg <= fifo_head[OFF_MASK +: 4];
            req_addr_reg <= fifo_head[OFF_ADDR +: 32];
            req_data_reg <= fifo_head[OFF_DATA +: 32];
            req_vld_reg  <= 1'b1;
            state_reg    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (RCN_REQ_RDY) begin
            req_vld_reg <= 1'b0;
            cnt_reg     <= 8'd0;
            state_reg   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg + 8'd1;
          if (rsp_done) begin
            err_reg   <= rsp_fail;
            state_reg <= ST_IDLE;
            if (wants_data) begin
              load_vld_reg <= 1'b1;
              load_sel_reg <= req_sel_reg;
              load_reg     <= load_data;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign RC_FULL      = fifo_full;
  assign RC_BUSY      = (fifo_count != '0) || (state_reg != ST_IDLE);
  assign RC_OVERFLOW  = overflow_reg;
  assign RCN_REQ_VLD  = req_vld_reg;
  assign RCN_REQ_ADDR = req_addr_reg;
  assign RCN_REQ_WR   = req_wr_reg;
  assign RCN_REQ_SWAP = req_swap_reg;
  assign RCN_REQ_MASK = req_mask_reg;
  assign RCN_REQ_DATA = req_data_reg;
  assign RC_LOAD_VLD  = load_vld_reg;
  assign RC_LOAD_SEL  = load_sel_reg;
  assign RC_LOAD      = load_reg;
  assign RC_ERR       = err_reg;

endmodule

// File: tb/tb_tawas_rcn_master.sv
// Self-checking bench for tawas_rcn_master: scoreboarded request and writeback
// channels plus per-scenario timing checks.
module tb_tawas_rcn_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RACCOON_CS = 1'b0;
  logic        RACCOON_SWAP = 1'b0;
  logic [2:0]  WRITEBACK_REG = '0;
  logic [31:0] DADDR = '0;
  logic        DWR = 1'b0;
  logic [3:0]  DMASK = '0;
  logic [31:0] DOUT = '0;
  logic        RC_FULL, RC_BUSY, RC_OVERFLOW;
  logic        RCN_REQ_VLD;
  logic        RCN_REQ_RDY = 1'b0;
  logic [31:0] RCN_REQ_ADDR;
  logic        RCN_REQ_WR, RCN_REQ_SWAP;
  logic [3:0]  RCN_REQ_MASK;
  logic [31:0] RCN_REQ_DATA;
  logic        RCN_RSP_VLD = 1'b0;
  logic        RCN_RSP_ERR = 1'b0;
  logic [31:0] RCN_RSP_DATA = '0;
  logic        RC_LOAD_VLD;
  logic [2:0]  RC_LOAD_SEL;
  logic [31:0] RC_LOAD;
  logic        RC_ERR;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic        swap;
    logic [3:0]  mask;
    logic [31:0] data;
  } req_t;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] data;
    logic        err;
  } wb_t;

  req_t exp_req[$];
  wb_t  exp_wb[$];
  req_t mon_req;
  req_t got_req;
  wb_t  mon_wb;
  wb_t  got_wb;

  int errors = 0;
  int checks = 0;

  tawas_rcn_master #(
    .DEPTH   (4),
    .TIMEOUT (8)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RACCOON_CS    (RACCOON_CS),
    .RACCOON_SWAP  (RACCOON_SWAP),
    .WRITEBACK_REG (WRITEBACK_REG),
    .DADDR         (DADDR),
    .DWR           (DWR),
    .DMASK         (DMASK),
    .DOUT          (DOUT),
    .RC_FULL       (RC_FULL),
    .RC_BUSY       (RC_BUSY),
    .RC_OVERFLOW   (RC_OVERFLOW),
    .RCN_REQ_VLD   (RCN_REQ_VLD),
    .RCN_REQ_RDY   (RCN_REQ_RDY),
    .RCN_REQ_ADDR  (RCN_REQ_ADDR),
    .RCN_REQ_WR    (RCN_REQ_WR),
    .RCN_REQ_SWAP  (RCN_REQ_SWAP),
    .RCN_REQ_MASK  (RCN_REQ_MASK),
    .RCN_REQ_DATA  (RCN_REQ_DATA),
    .RCN_RSP_VLD   (RCN_RSP_VLD),
    .RCN_RSP_ERR   (RCN_RSP_ERR),
    .RCN_RSP_DATA  (RCN_RSP_DATA),
    .RC_LOAD_VLD   (RC_LOAD_VLD),
    .RC_LOAD_SEL   (RC_LOAD_SEL),
    .RC_LOAD       (RC_LOAD),
    .RC_ERR        (RC_ERR)
  );

  always #5 CLK = ~CLK;

  // Channel monitors: sampled on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (!RST) begin
      if (RCN_REQ_VLD && RCN_REQ_RDY) begin
        got_req = '{RCN_REQ_ADDR, RCN_REQ_WR, RCN_REQ_SWAP, RCN_REQ_MASK, RCN_REQ_DATA};
        $display("req  addr=%h wr=%0b swap=%0b mask=%b data=%h", got_req.addr, got_req.wr,
                 got_req.swap, got_req.mask, got_req.data);
        checks++;
        if (exp_req.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected got addr=%h, required no request", got_req.addr);
        end else begin
          mon_req = exp_req.pop_front();
          if (got_req !== mon_req) begin
            errors++;
            $display("FAIL req_fields got %h, required %h", got_req, mon_req);
          end
        end
      end
      if (RC_LOAD_VLD || RC_ERR) begin
        got_wb = '{RC_LOAD_SEL, RC_LOAD, RC_ERR};
        $display("wb   vld=%0b sel=%0d data=%h err=%0b", RC_LOAD_VLD, got_wb.sel, got_wb.data,
                 got_wb.err);
        checks++;
        if (exp_wb.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected got vld=%0b data=%h err=%0b, required none", RC_LOAD_VLD,
                   got_wb.data, got_wb.err);
        end else begin
          mon_wb = exp_wb.pop_front();
          if (got_wb !== mon_wb || RC_LOAD_VLD !== 1'b1) begin
            errors++;
            $display("FAIL wb_fields got sel=%0d data=%h err=%0b, required sel=%0d data=%h err=%0b",
                     got_wb.sel, got_wb.data, got_wb.err, mon_wb.sel, mon_wb.data, mon_wb.err);
          end
        end
      end else begin
        checks++;
        if (RC_LOAD !== 32'd0) begin
          errors++;
          $display("FAIL load_idle_zero got %h, required 0", RC_LOAD);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Pulse RACCOON_CS for one edge; keep=1 queues the request expectation.
  task automatic issue(input logic swap, input logic wr, input logic [2:0] sel,
                       input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, input logic keep);
    RACCOON_SWAP  = swap;
    DWR           = wr;
    WRITEBACK_REG = sel;
    DADDR         = addr;
    DMASK         = mask;
    DOUT          = data;
    RACCOON_CS    = 1'b1;
    if (keep) exp_req.push_back('{addr, wr, swap, mask, data});
    tick();
    RACCOON_CS = 1'b0;
  endtask

  // Returns one time unit after the edge that accepts a request.
  task automatic wait_accept(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge CLK);
      if (RCN_REQ_VLD && RCN_REQ_RDY) seen = 1'b1;
      @(posedge CLK);
      #1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout got no accept, required accept within 60 cycles", name);
    end
  endtask

  task automatic respond(input logic [31:0] data, input logic err);
    RCN_RSP_VLD  = 1'b1;
    RCN_RSP_ERR  = err;
    RCN_RSP_DATA = data;
    tick();
    RCN_RSP_VLD  = 1'b0;
    RCN_RSP_ERR  = 1'b0;
    RCN_RSP_DATA = 32'd0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    checks++;
    if ({RCN_REQ_VLD, RC_FULL, RC_BUSY, RC_OVERFLOW, RC_LOAD_VLD, RC_ERR} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b, required 000000",
               {RCN_REQ_VLD, RC_FULL, RC_BUSY, RC_OVERFLOW, RC_LOAD_VLD, RC_ERR});
    end
    checks++;
    if ({RCN_REQ_ADDR, RCN_REQ_DATA, RC_LOAD} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data got addr=%h data=%h load=%h, required 0", RCN_REQ_ADDR,
               RCN_REQ_DATA, RC_LOAD);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_read_basic();
    RCN_REQ_RDY = 1'b1;
    exp_wb.push_back('{3'd5, 32'hCAFE_BABE, 1'b0});
    issue(1'b0, 1'b0, 3'd5, 32'h0100_0004, 4'b1111, 32'h0, 1'b1);
    checks++;
    if (RCN_REQ_VLD !== 1'b0) begin
      errors++;
      $display("FAIL read_vld_after_e0 got %b, required 0", RCN_REQ_VLD);
    end
    tick();
    checks++;
    if (RCN_REQ_VLD !== 1'b1) begin
      errors++;
      $display("FAIL read_vld_after_e1 got %b, required 1", RCN_REQ_VLD);
    end
    wait_accept("read");
    tick();
    respond(32'hCAFE_BABE, 1'b0);
    checks++;
    if (RC_LOAD_VLD !== 1'b1) begin
      errors++;
      $display("FAIL read_wb_pulse got %b, required 1", RC_LOAD_VLD);
    end
    tick();
    checks++;
    if (RC_LOAD_VLD !== 1'b0 || RC_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL read_wb_end got vld=%b busy=%b, required 0 0", RC_LOAD_VLD, RC_BUSY);
    end
  endtask

  task automatic test_lanes();
    logic [3:0]  masks[6];
    logic [31:0] expd[6];
    masks = '{4'b0100, 4'b1100, 4'b0001, 4'b1000, 4'b0011, 4'b0101};
    expd  = '{32'h22, 32'h1122, 32'h44, 32'h11, 32'h3344, 32'h1122_3344};
    for (int i = 0; i < 6; i++) begin
      exp_wb.push_back('{3'(i + 1), expd[i], 1'b0});
      issue(1'b0, 1'b0, 3'(i + 1), 32'h0200_0000 + 32'(i * 4), masks[i], 32'h0, 1'b1);
      wait_accept("lanes");
      respond(32'h1122_3344, 1'b0);
    end
    tick();
  endtask

  task automatic test_write_swap();
    issue(1'b0, 1'b1, 3'd6, 32'h0300_0010, 4'b0001, 32'hA5A5_A5A5, 1'b1);
    wait_accept("write");
    respond(32'hDEAD_0000, 1'b0);
    checks++;
    if (RC_LOAD_VLD !== 1'b0) begin
      errors++;
      $display("FAIL write_no_wb got %b, required 0", RC_LOAD_VLD);
    end
    exp_wb.push_back('{3'd7, 32'h77, 1'b0});
    issue(1'b1, 1'b1, 3'd7, 32'h0300_0020, 4'b1111, 32'h1234_5678, 1'b1);
    wait_accept("swap");
    respond(32'h77, 1'b0);
    checks++;
    if (RC_LOAD_VLD !== 1'b1) begin
      errors++;
      $display("FAIL swap_wb got %b, required 1", RC_LOAD_VLD);
    end
    tick();
  endtask

  task automatic test_backpressure();
    RCN_REQ_RDY = 1'b0;
    exp_wb.push_back('{3'd1, 32'h1000_0001, 1'b0});
    issue(1'b0, 1'b0, 3'd1, 32'h0400_0004, 4'b1111, 32'h0, 1'b1);
    tick();
    for (int i = 2; i <= 5; i++) begin
      exp_wb.push_back('{3'(i), 32'h1000_0000 + 32'(i), 1'b0});
      issue(1'b0, 1'b0, 3'(i), 32'h0400_0000 + 32'(i * 4), 4'b1111, 32'h0, 1'b1);
      if (i >= 4) begin
        checks++;
        if (RC_FULL !== (i == 5)) begin
          errors++;
          $display("FAIL bp_full_after_%0d got %b, required %b", i, RC_FULL, i == 5);
        end
      end
    end
    issue(1'b0, 1'b0, 3'd6, 32'h0400_0018, 4'b1111, 32'h0, 1'b0);
    checks++;
    if (RC_OVERFLOW !== 1'b1 || RC_FULL !== 1'b1) begin
      errors++;
      $display("FAIL bp_overflow got ovf=%b full=%b, required 1 1", RC_OVERFLOW, RC_FULL);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (RCN_REQ_VLD !== 1'b1 || RCN_REQ_ADDR !== 32'h0400_0004 || RCN_REQ_MASK !== 4'b1111
          || RCN_REQ_WR !== 1'b0) begin
        errors++;
        $display("FAIL bp_stable cycle %0d got vld=%b addr=%h, required 1 04000004", c,
                 RCN_REQ_VLD, RCN_REQ_ADDR);
      end
    end
    RCN_REQ_RDY = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wait_accept("bp");
      respond(32'h1000_0000 + 32'(i), 1'b0);
    end
    tick();
    checks++;
    if (RC_OVERFLOW !== 1'b1 || RC_FULL !== 1'b0 || RC_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained got ovf=%b full=%b busy=%b, required 1 0 0", RC_OVERFLOW,
               RC_FULL, RC_BUSY);
    end
  endtask

  task automatic test_timeout();
    exp_wb.push_back('{3'd3, 32'hFFFF_FFFF, 1'b1});
    issue(1'b0, 1'b0, 3'd3, 32'h0500_0000, 4'b0011, 32'h0, 1'b1);
    wait_accept("timeout");
    repeat (7) tick();
    checks++;
    if (RC_ERR !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got %b, required 0", RC_ERR);
    end
    tick();
    checks++;
    if (RC_ERR !== 1'b1 || RC_LOAD_VLD !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire got err=%b vld=%b, required 1 1", RC_ERR, RC_LOAD_VLD);
    end
    respond(32'h0BAD_0BAD, 1'b0);
    tick();
    checks++;
    if (RC_LOAD_VLD !== 1'b0 || RC_ERR !== 1'b0) begin
      errors++;
      $display("FAIL late_rsp got vld=%b err=%b, required 0 0", RC_LOAD_VLD, RC_ERR);
    end
  endtask

  task automatic test_error_reset();
    exp_wb.push_back('{3'd2, 32'hFFFF_FFFF, 1'b1});
    issue(1'b0, 1'b0, 3'd2, 32'h0600_0000, 4'b0001, 32'h0, 1'b1);
    wait_accept("rsp_err");
    respond(32'h1234_5678, 1'b1);
    checks++;
    if (RC_ERR !== 1'b1) begin
      errors++;
      $display("FAIL rsp_err_pulse got %b, required 1", RC_ERR);
    end
    tick();
    RCN_REQ_RDY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b1, 3'd0, 32'h0700_0000 + 32'(i * 4), 4'b1111, 32'(i), 1'b0);
    end
    checks++;
    if (RCN_REQ_VLD !== 1'b1 || RC_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got vld=%b busy=%b, required 1 1", RCN_REQ_VLD, RC_BUSY);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({RCN_REQ_VLD, RC_BUSY, RC_FULL, RC_OVERFLOW, RC_LOAD_VLD, RC_ERR} !== 6'b0
        || RCN_REQ_ADDR !== 32'd0 || RC_LOAD !== 32'd0) begin
      errors++;
      $display("FAIL async_rst got vld=%b busy=%b full=%b addr=%h, required 0", RCN_REQ_VLD,
               RC_BUSY, RC_FULL, RCN_REQ_ADDR);
    end
    tick();
    RST = 1'b0;
    RCN_REQ_RDY = 1'b1;
    repeat (4) tick();
    checks++;
    if (RCN_REQ_VLD !== 1'b0 || RC_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL flushed got vld=%b busy=%b, required 0 0", RCN_REQ_VLD, RC_BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_lanes();
    test_write_swap();
    test_backpressure();
    test_timeout();
    test_error_reset();
    checks++;
    if (exp_req.size() != 0 || exp_wb.size() != 0) begin
      errors++;
      $display("FAIL leftover got req=%0d wb=%0d pending, required 0 0", exp_req.size(),
               exp_wb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
